// File: rtl/gf180mcu_osu_sc_gp12t3v3_drive_seq.sv
// Staggered thermometer enable sequencer for a segmented driver bank; walks LVL one segment per STEP_CYCLES clocks.
// Optional: define GF180MCU_OSU_SC_DRIVE_SEQ_RETARGET_EN to let REQ retarget a ramp in progress.
module gf180mcu_osu_sc_gp12t3v3_drive_seq #(
  parameter int NSEG        = 8,
  parameter int STEP_CYCLES = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ,
  input  logic [3:0]      TGT,
  output logic            ACK,
  output logic            BUSY,
  output logic [3:0]      LVL,
  output logic [NSEG-1:0] EN
);

  localparam int              CW     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0]   RELOAD = CW'(STEP_CYCLES - 1);
  localparam logic [3:0]      NSEG_L = 4'(NSEG);

  typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    tgt;
  logic [3:0]    req_tgt;
  logic [3:0]    ramp_tgt;
  logic [3:0]    lvl_step;

  function automatic logic [NSEG-1:0] therm(input logic [3:0] n);
    logic [NSEG-1:0] t;
    for (int i = 0; i < NSEG; i++) t[i] = (i < int'(n));
    return t;
  endfunction

  // NOTE: every combinational output gets a value on every path, so no latch can be inferred.
  always_comb begin
    req_tgt = (TGT > NSEG_L) ? NSEG_L : TGT;
`ifdef GF180MCU_OSU_SC_DRIVE_SEQ_RETARGET_EN
    ramp_tgt = REQ ? req_tgt : tgt;
`else
    ramp_tgt = tgt;
`endif
    lvl_step = (ramp_tgt > LVL) ? LVL + 4'd1 : LVL - 4'd1;
  end

  // EN is loaded from the same next-level value as LVL, so both change on one edge with no decode glitch.
  // NOTE: all state and outputs are registers updated with non-blocking assignments.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      tgt   <= '0;
      LVL   <= '0;
      EN    <= '0;
      BUSY  <= 1'b0;
      ACK   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ACK <= 1'b0;
          if (REQ) begin
            tgt <= req_tgt;
            if (req_tgt != LVL) begin
              state <= RAMP;
              BUSY  <= 1'b1;
              cnt   <= RELOAD;
            end else begin
              state <= DONE;
              ACK   <= 1'b1;
            end
          end
        end
        RAMP: begin
          tgt <= ramp_tgt;
          if (ramp_tgt == LVL) begin
            // Only reachable when a retarget lands exactly on the current level.
            state <= DONE;
            BUSY  <= 1'b0;
            ACK   <= 1'b1;
          end else if (cnt == '0) begin
            LVL <= lvl_step;
            EN  <= therm(lvl_step);
            cnt <= RELOAD;
            if (lvl_step == ramp_tgt) begin
              state <= DONE;
              BUSY  <= 1'b0;
              ACK   <= 1'b1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          ACK   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_lvl_range: assert property (@(posedge CLK) disable iff (RST) LVL <= NSEG_L);
  a_en_decode: assert property (@(posedge CLK) disable iff (RST) EN == therm(LVL));
  a_busy_ramp: assert property (@(posedge CLK) disable iff (RST) BUSY == (state == RAMP));

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3_drive_seq.sv
// Directed bench for the drive sequencer at NSEG=8, STEP_CYCLES=4; outputs sampled on the falling edge.
module tb_gf180mcu_osu_sc_gp12t3v3_drive_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ = 1'b0;
  logic [3:0] TGT = 4'd0;
  logic       ACK;
  logic       BUSY;
  logic [3:0] LVL;
  logic [7:0] EN;

  int compared   = 0;
  int mismatched = 0;

  gf180mcu_osu_sc_gp12t3v3_drive_seq #(.NSEG(8), .STEP_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .TGT(TGT),
    .ACK(ACK), .BUSY(BUSY), .LVL(LVL), .EN(EN)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] therm8(input int n);
    logic [8:0] v;
    v = (9'd1 << n) - 9'd1;
    return v[7:0];
  endfunction

  // Issues one request and follows the whole ramp edge by edge; k counts edges after the accepting edge.
  task automatic run_ramp(input string name, input int start, input logic [3:0] req, input int fin);
    int d, total, steps, lvl_exp;
    logic busy_exp, ack_exp;
    d     = (fin > start) ? fin - start : start - fin;
    total = d * 4;
    @(negedge CLK);
    REQ = 1'b1; TGT = req;
    @(negedge CLK);
    REQ = 1'b0;
    for (int k = 0; k <= total + 1; k++) begin
      if (k != 0) @(negedge CLK);
      steps    = (k / 4 > d) ? d : k / 4;
      lvl_exp  = (fin >= start) ? start + steps : start - steps;
      busy_exp = (k < total);
      ack_exp  = (k == total);
      compared++;
      if (LVL !== 4'(lvl_exp)) begin
        mismatched++;
        $display("FAIL %s k=%0d LVL got %0d want %0d", name, k, LVL, lvl_exp);
      end
      compared++;
      if (EN !== therm8(lvl_exp)) begin
        mismatched++;
        $display("FAIL %s k=%0d EN got %02h want %02h", name, k, EN, therm8(lvl_exp));
      end
      compared++;
      if (BUSY !== busy_exp) begin
        mismatched++;
        $display("FAIL %s k=%0d BUSY got %b want %b", name, k, BUSY, busy_exp);
      end
      compared++;
      if (ACK !== ack_exp) begin
        mismatched++;
        $display("FAIL %s k=%0d ACK got %b want %b", name, k, ACK, ack_exp);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    compared++;
    if (EN !== 8'h00) begin mismatched++; $display("FAIL reset EN got %02h want 00", EN); end
    compared++;
    if (LVL !== 4'd0) begin mismatched++; $display("FAIL reset LVL got %0d want 0", LVL); end
    compared++;
    if (BUSY !== 1'b0) begin mismatched++; $display("FAIL reset BUSY got %b want 0", BUSY); end
    compared++;
    if (ACK !== 1'b0) begin mismatched++; $display("FAIL reset ACK got %b want 0", ACK); end
    // Reset must win over a coincident request.
    REQ = 1'b1; TGT = 4'd5;
    @(negedge CLK);
    RST = 1'b0; REQ = 1'b0;
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (LVL !== 4'd0 || ACK !== 1'b0 || BUSY !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_req k=%0d LVL/ACK/BUSY got %0d/%b/%b want 0/0/0", k, LVL, ACK, BUSY);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_ramp_up();
    run_ramp("ramp_up", 0, 4'd3, 3);
  endtask

  task automatic test_ramp_down_clamp();
    run_ramp("ramp_down", 3, 4'd1, 1);
    apply_reset();
    run_ramp("clamp", 0, 4'd12, 8);
  endtask

  task automatic test_same_level();
    run_ramp("same_level", 8, 4'd8, 8);
    repeat (2) begin
      @(negedge CLK);
      compared++;
      if (BUSY !== 1'b0 || ACK !== 1'b0 || EN !== 8'hFF) begin
        mismatched++;
        $display("FAIL same_level_after BUSY/ACK/EN got %b/%b/%02h want 0/0/ff", BUSY, ACK, EN);
      end
    end
  endtask

  task automatic test_mid_ramp_reset();
    apply_reset();
    @(negedge CLK);
    REQ = 1'b1; TGT = 4'd6;
    @(negedge CLK);
    REQ = 1'b0;
    repeat (9) @(negedge CLK);
    compared++;
    if (LVL !== 4'd2) begin mismatched++; $display("FAIL mid_reset pre LVL got %0d want 2", LVL); end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    compared++;
    if (EN !== 8'h00 || LVL !== 4'd0 || BUSY !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset EN/LVL/BUSY got %02h/%0d/%b want 00/0/0", EN, LVL, BUSY);
    end
    for (int k = 0; k < 20; k++) begin
      compared++;
      if (ACK !== 1'b0 || LVL !== 4'd0) begin
        mismatched++;
        $display("FAIL mid_reset_quiet k=%0d ACK/LVL got %b/%0d want 0/0", k, ACK, LVL);
      end
      @(negedge CLK);
    end
    run_ramp("after_reset", 0, 4'd1, 1);
  endtask

  task automatic test_req_during_ramp();
    int acks;
    logic [3:0] lvl_at16;
    apply_reset();
    @(negedge CLK);
    REQ = 1'b1; TGT = 4'd5;
    @(negedge CLK);
    REQ = 1'b0;
    repeat (12) @(negedge CLK);
    compared++;
    if (LVL !== 4'd3) begin mismatched++; $display("FAIL retarget pre LVL got %0d want 3", LVL); end
    REQ = 1'b1; TGT = 4'd2;
    @(negedge CLK);
    REQ = 1'b0;
    acks = 0;
    lvl_at16 = 4'hF;
    // k counts edges after the original accepting edge.
    for (int k = 13; k <= 30; k++) begin
      if (k != 13) @(negedge CLK);
      if (ACK === 1'b1) acks++;
      if (k == 16) lvl_at16 = LVL;
    end
    compared++;
    if (acks != 1) begin mismatched++; $display("FAIL retarget ack_count got %0d want 1", acks); end
`ifdef GF180MCU_OSU_SC_DRIVE_SEQ_RETARGET_EN
    compared++;
    if (lvl_at16 !== 4'd2) begin mismatched++; $display("FAIL retarget LVL@16 got %0d want 2", lvl_at16); end
    compared++;
    if (EN !== 8'h03 || LVL !== 4'd2) begin
      mismatched++;
      $display("FAIL retarget final EN/LVL got %02h/%0d want 03/2", EN, LVL);
    end
`else
    compared++;
    if (lvl_at16 !== 4'd4) begin mismatched++; $display("FAIL retarget LVL@16 got %0d want 4", lvl_at16); end
    compared++;
    if (EN !== 8'h1F || LVL !== 4'd5) begin
      mismatched++;
      $display("FAIL retarget final EN/LVL got %02h/%0d want 1f/5", EN, LVL);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down_clamp();
    test_same_level();
    test_mid_ramp_reset();
    test_req_during_ramp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3_drive_seq.md
# gf180mcu_osu_sc_gp12t3v3_drive_seq

Staggered enable sequencer for a segmented output driver built from parallel unit inverter fingers, as in the x8 inverter cells of the gp12t3v3 library. It accepts a requested drive strength and walks a thermometer-coded segment-enable bus one segment at a time, a fixed number of clocks apart, to limit supply di/dt. It sits beside the driver bank in pad-ring and clock-buffer macros and is the only block that writes the bank's segment enables.

## Interface

- NSEG, 8: number of driver segments, 1..15.
- STEP_CYCLES, 4: clocks between successive segment changes, ≥1.
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- REQ  input  1  single-cycle request strobe.
- TGT  input  4  requested segment count; values above NSEG are clamped to NSEG.
- ACK  output 1  one-cycle completion pulse.
- BUSY output 1  high while a ramp is in progress.
- LVL  output 4  current number of enabled segments.
- EN   output NSEG  thermometer enables; EN[i]=1 iff i<LVL.

One clock (CLK); reset is synchronous and active-high (RST), sampled only on the CLK rising edge.

## Operation

- The FSM has three states: IDLE, RAMP and DONE.
- IDLE:
  - REQ=1 captures tgt=min(TGT,NSEG).
  - If tgt≠LVL: go to RAMP and load the step counter with STEP_CYCLES-1.
  - If tgt==LVL: go to DONE.
- RAMP:
  - Each cycle, decrement the counter.
  - On a cycle where counter==0: step LVL by ±1 toward tgt and reload STEP_CYCLES-1.
  - When the step makes LVL==tgt: go to DONE on that same edge.
- DONE:
  - ACK=1 for exactly one cycle; then return to IDLE.
  - REQ in DONE is ignored.
- LVL never moves more than 1 per step and never leaves 0..NSEG.
- EN is a registered decode of LVL with no glitch path: EN and LVL update on the same edge.
- RST has priority over everything, including a simultaneous REQ.
  - Reset values: state=IDLE, LVL=0, EN=0, BUSY=0, ACK=0, counter=0, tgt=0.
  - Reset mid-ramp drops all enables at the reset edge; there is no ramp-down.
- In RAMP without the configured feature, REQ is ignored and not queued.

## Timing

- Define t0 as the edge at which REQ is accepted in IDLE, and d=|tgt−LVL|.
- BUSY is high from t0 through the edge at t0+d·STEP_CYCLES, and low after it.
- LVL changes at edges t0+k·STEP_CYCLES for k=1..d.
- The state is DONE after edge t0+d·STEP_CYCLES. ACK is high for the following cycle and low again after edge t0+d·STEP_CYCLES+1.
- A new REQ is accepted no earlier than edge t0+d·STEP_CYCLES+2, i.e. back in IDLE.
- Same-level request (d=0): ACK is high in the cycle after t0, BUSY stays 0 and EN is unchanged.
- STEP_CYCLES=1 steps LVL on every edge.

## Configuration

- GF180MCU_OSU_SC_DRIVE_SEQ_RETARGET_EN defined:
  - REQ during RAMP replaces tgt with min(TGT,NSEG). The step counter is not reloaded.
  - The ramp direction follows the new tgt from the current LVL.
  - If the new tgt equals LVL, go to DONE at that edge.
  - Only one ACK is issued, for the final target.
- Not defined: REQ during RAMP is ignored; the original ramp completes and ACKs.

## Test plan

All scenarios use NSEG=8 and STEP_CYCLES=4.

- Reset: hold RST for 2 cycles → EN=0x00, LVL=0, BUSY=0, ACK=0. RST together with REQ/TGT=5 → LVL stays 0 and no ACK.
- Ramp up: REQ with TGT=3 from LVL=0 at t0 → EN=0x01 at t0+4, 0x03 at t0+8, 0x07 at t0+12. BUSY is high t0..t0+12 and ACK is high for exactly one cycle after t0+12.
- Ramp down and clamp:
  - From LVL=3, TGT=1 → EN 0x03 at +4, 0x01 at +8, then ACK.
  - TGT=12 from LVL=0 → EN=0xFF at +32, LVL=8.
- Same level: from LVL=8, REQ with TGT=8 → ACK in the next cycle, BUSY never rises, EN stays 0xFF.
- Mid-ramp reset: assert RST when LVL=2 during a ramp to 6 → EN=0x00 at the reset edge, no ACK. A subsequent REQ with TGT=1 ramps normally.
- REQ during RAMP, ramp 0→5, second REQ with TGT=2 at LVL=3:
  - Macro off: ramp finishes at 5 (EN=0x1F) with a single ACK.
  - Macro on: LVL goes 3→2, then ACK once, final EN=0x03.
